// File: rtl/timer_ctrl.sv
// Sequencing and compare/interrupt controller for timer_core: start/stop/reload sequencing,
// compare match detection, sticky interrupt with overrun, and a match event counter.
module timer_ctrl #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MATCH_CNT_W = 16
) (
  input  logic                   axi_clk,
  input  logic                   rst_n,
  input  logic                   cfg_start,
  input  logic                   cfg_stop,
  input  logic                   cfg_periodic,
  input  logic [CNT_W-1:0]       cfg_compare,
  input  logic [31:0]            cfg_prescaler,
  input  logic                   cfg_irq_en,
  input  logic                   irq_clear,
  input  logic [CNT_W-1:0]       counter,
  output logic                   tmr_enable,
  output logic                   tmr_reset_counter,
  output logic [31:0]            tmr_prescaler,
  output logic                   busy,
  output logic                   done,
  output logic                   irq,
  output logic                   irq_status,
  output logic                   overrun,
  output logic                   cfg_err,
  output logic [MATCH_CNT_W-1:0] match_count
);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRun,
    StReload,
    StDone
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       compare_q, compare_d;
  logic [31:0]            prescaler_q, prescaler_d;
  logic                   irq_status_q, irq_status_d;
  logic                   overrun_q, overrun_d;
  logic                   cfg_err_q, cfg_err_d;
  logic [MATCH_CNT_W-1:0] match_count_q, match_count_d;

  logic match_hit;
  logic compare_ok;

  assign match_hit  = (state_q == StRun) && (counter == compare_q);
  assign compare_ok = (cfg_compare != '0);

  always_comb begin
    state_d       = state_q;
    compare_d     = compare_q;
    prescaler_d   = prescaler_q;
    irq_status_d  = irq_clear ? 1'b0 : irq_status_q;
    overrun_d     = overrun_q;
    cfg_err_d     = cfg_err_q;
    match_count_d = match_count_q;

    // Stop outranks start and any match in the same cycle.
    if (cfg_stop) begin
      state_d = StIdle;
    end else if (cfg_start) begin
      if (compare_ok) begin
        compare_d     = cfg_compare;
        prescaler_d   = cfg_prescaler;
        match_count_d = '0;
        overrun_d     = 1'b0;
        cfg_err_d     = 1'b0;
        state_d       = StClear;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        StIdle:  state_d = StIdle;
        StClear: state_d = StRun;
        StRun: begin
          if (match_hit) begin
            // Match set wins over a same-cycle clear; overrun only if the flag survives.
            irq_status_d  = 1'b1;
            match_count_d = match_count_q + 1'b1;
            if (irq_status_q && !irq_clear) begin
              overrun_d = 1'b1;
            end
            state_d = cfg_periodic ? StReload : StDone;
          end
        end
        StReload: begin
          if (compare_ok) begin
            compare_d   = cfg_compare;
            prescaler_d = cfg_prescaler;
          end
          state_d = StRun;
        end
        StDone:  state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge axi_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      compare_q     <= '0;
      prescaler_q   <= '0;
      irq_status_q  <= 1'b0;
      overrun_q     <= 1'b0;
      cfg_err_q     <= 1'b0;
      match_count_q <= '0;
    end else begin
      state_q       <= state_d;
      compare_q     <= compare_d;
      prescaler_q   <= prescaler_d;
      irq_status_q  <= irq_status_d;
      overrun_q     <= overrun_d;
      cfg_err_q     <= cfg_err_d;
      match_count_q <= match_count_d;
    end
  end

  // Enable drops combinationally on the match cycle so the core holds the compare value.
  assign tmr_enable        = (state_q == StRun) && !match_hit;
  assign tmr_reset_counter = (state_q == StClear) || (state_q == StReload);
  assign tmr_prescaler     = prescaler_q;
  assign busy              = (state_q == StClear) || (state_q == StRun) || (state_q == StReload);
  assign done              = (state_q == StDone);
  assign irq_status        = irq_status_q;
  assign irq               = irq_status_q && cfg_irq_en;
  assign overrun           = overrun_q;
  assign cfg_err           = cfg_err_q;
  assign match_count       = match_count_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: behavioural timer_core plant, match-time scoreboard derived from the
// K(P+1)+2 timing rule, directed scenarios plus randomized runs.
module tb_timer_ctrl;

  logic        axi_clk;
  logic        rst_n;
  logic        cfg_start;
  logic        cfg_stop;
  logic        cfg_periodic;
  logic [31:0] cfg_compare;
  logic [31:0] cfg_prescaler;
  logic        cfg_irq_en;
  logic        irq_clear;
  logic [31:0] counter;
  logic        tmr_enable;
  logic        tmr_reset_counter;
  logic [31:0] tmr_prescaler;
  logic        busy;
  logic        done;
  logic        irq;
  logic        irq_status;
  logic        overrun;
  logic        cfg_err;
  logic [15:0] match_count;

  timer_ctrl #(
    .CNT_W       (32),
    .MATCH_CNT_W (16)
  ) dut (
    .axi_clk           (axi_clk),
    .rst_n             (rst_n),
    .cfg_start         (cfg_start),
    .cfg_stop          (cfg_stop),
    .cfg_periodic      (cfg_periodic),
    .cfg_compare       (cfg_compare),
    .cfg_prescaler     (cfg_prescaler),
    .cfg_irq_en        (cfg_irq_en),
    .irq_clear         (irq_clear),
    .counter           (counter),
    .tmr_enable        (tmr_enable),
    .tmr_reset_counter (tmr_reset_counter),
    .tmr_prescaler     (tmr_prescaler),
    .busy              (busy),
    .done              (done),
    .irq               (irq),
    .irq_status        (irq_status),
    .overrun           (overrun),
    .cfg_err           (cfg_err),
    .match_count       (match_count)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  // Prescaled counter plant standing in for timer_core.
  logic [31:0] pres_cnt;
  always @(posedge axi_clk or negedge rst_n) begin
    if (!rst_n) begin
      counter  <= '0;
      pres_cnt <= '0;
    end else if (tmr_reset_counter) begin
      counter  <= '0;
      pres_cnt <= '0;
    end else if (tmr_enable) begin
      if (pres_cnt >= tmr_prescaler) begin
        pres_cnt <= '0;
        counter  <= counter + 1;
      end else begin
        pres_cnt <= pres_cnt + 1;
      end
    end
  end

  int unsigned cyc;
  always @(posedge axi_clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    int unsigned cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors;
  int   miscompares;
  logic [15:0] prev_mc;

  // Monitor: every new nonzero match_count value is a match event to be matched against the queue.
  always @(negedge axi_clk) begin
    if (rst_n && match_count != prev_mc && match_count != '0) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_match: cycle %0d count %0d, none required", cyc, match_count);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.cyc != cyc || mon_e.cnt != 32'(match_count) || !irq_status) begin
          miscompares++;
          $display("FAIL match_event: got cycle %0d count %0d irq_status %0b, need cycle %0d count %0d irq_status 1",
                   cyc, match_count, irq_status, mon_e.cyc, mon_e.cnt);
        end
      end
    end
    prev_mc = match_count;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, need %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(negedge axi_clk);
  endtask

  task automatic wait_until(input int unsigned t);
    while (cyc < t) @(negedge axi_clk);
  endtask

  // Clears the irq flag, then issues a start; returns the start edge index.
  task automatic do_start(input int unsigned k, input int unsigned p, input logic per,
                          input logic en, output int unsigned e0);
    irq_clear = 1'b1;
    tick();
    irq_clear     = 1'b0;
    cfg_compare   = k;
    cfg_prescaler = p;
    cfg_periodic  = per;
    cfg_irq_en    = en;
    cfg_start     = 1'b1;
    e0            = cyc + 1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic do_stop();
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
  endtask

  task automatic push_matches(input int unsigned e0, input int unsigned k, input int unsigned p,
                              input int unsigned m);
    int unsigned per;
    per = k * (p + 1) + 2;
    for (int n = 1; n <= int'(m); n++) exp_q.push_back('{cyc: e0 + n * per, cnt: n});
  endtask

  initial begin
    int unsigned e0;
    int unsigned k, p, m;
    logic        per, en;

    vectors       = 0;
    miscompares   = 0;
    prev_mc       = '0;
    rst_n         = 1'b0;
    cfg_start     = 1'b0;
    cfg_stop      = 1'b0;
    cfg_periodic  = 1'b0;
    cfg_compare   = '0;
    cfg_prescaler = '0;
    cfg_irq_en    = 1'b0;
    irq_clear     = 1'b0;
    repeat (2) tick();
    check("reset_flags", {tmr_enable, tmr_reset_counter, busy, done, irq, irq_status, overrun,
                          cfg_err}, '0);
    check("reset_counts", {tmr_prescaler, match_count}, '0);
    rst_n = 1'b1;
    repeat (2) tick();

    // One-shot K=3 P=0: counter holds 3, irq at E5.
    do_start(3, 0, 1'b0, 1'b1, e0);
    push_matches(e0, 3, 0, 1);
    wait_until(e0 + 4);
    check("t1_cnt_at_match", counter, 3);
    check("t1_enable_at_match", tmr_enable, 0);
    check("t1_irq_before", irq_status, 0);
    tick();
    check("t1_done", {done, irq_status, irq}, 3'b111);
    repeat (3) tick();
    check("t1_cnt_hold", {counter, 31'd0, tmr_enable}, {32'd3, 32'd0});
    do_stop();

    // Periodic K=2 P=1: matches every 6 cycles, overrun on 2nd, clear vs match on 3rd.
    do_start(2, 1, 1'b1, 1'b1, e0);
    push_matches(e0, 2, 1, 3);
    wait_until(e0 + 5);
    check("t2_irq_low", irq, 0);
    wait_until(e0 + 6);
    check("t2_irq_reload", {irq, tmr_reset_counter}, 2'b11);
    tick();
    check("t2_reload_pulse", {tmr_reset_counter, busy}, 2'b01);
    wait_until(e0 + 12);
    check("t2_count2", match_count, 2);
    check("t3_overrun", overrun, 1);
    tick();
    irq_clear = 1'b1;
    tick();
    irq_clear = 1'b0;
    check("t3_cleared", irq_status, 0);
    wait_until(e0 + 17);
    irq_clear = 1'b1;
    tick();
    irq_clear = 1'b0;
    check("t3_match_beats_clear", irq_status, 1);
    do_stop();

    // Zero compare errs without starting; a later legal start clears the error.
    cfg_compare = '0;
    cfg_start   = 1'b1;
    tick();
    cfg_start = 1'b0;
    check("t4_err", {cfg_err, busy, tmr_enable}, 3'b100);
    tick();
    check("t4_idle", busy, 0);
    do_start(5, 0, 1'b0, 1'b0, e0);
    check("t4_err_cleared", {cfg_err, busy}, 2'b01);
    push_matches(e0, 5, 0, 1);
    wait_until(e0 + 7);
    check("t4_done", {done, irq}, 2'b10);
    do_stop();

    // Stop lands on the edge where the counter reaches 2.
    do_start(4, 0, 1'b0, 1'b1, e0);
    wait_until(e0 + 2);
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    check("t5_stopped", {busy, counter}, {1'b0, 32'd2});
    repeat (6) tick();
    check("t5_frozen", counter, 2);
    check("t5_no_irq", {irq_status, match_count}, '0);
    cfg_compare = 4;
    cfg_start   = 1'b1;
    cfg_stop    = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_stop  = 1'b0;
    check("t5_stop_beats_start", {busy, tmr_reset_counter, tmr_enable}, 3'b000);

    // Asynchronous reset mid-run.
    do_start(6, 2, 1'b1, 1'b1, e0);
    wait_until(e0 + 3);
    check("t6_running", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_flags", {tmr_enable, tmr_reset_counter, busy, done, irq, irq_status, overrun,
                             cfg_err}, '0);
    check("t6_async_counts", {tmr_prescaler, match_count}, '0);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("t6_idle_after", {busy, tmr_enable, counter}, '0);

    // Periodic retime: first match at K=4, then period K=2 after reload.
    do_start(4, 0, 1'b1, 1'b0, e0);
    cfg_compare = 2;
    exp_q.push_back('{cyc: e0 + 6, cnt: 1});
    exp_q.push_back('{cyc: e0 + 10, cnt: 2});
    exp_q.push_back('{cyc: e0 + 14, cnt: 3});
    wait_until(e0 + 14);
    check("t7_count", match_count, 3);
    do_stop();

    // Randomized runs.
    for (int i = 0; i < 12; i++) begin
      k   = $urandom_range(1, 6);
      p   = $urandom_range(0, 3);
      per = 1'($urandom_range(0, 1));
      en  = 1'($urandom_range(0, 1));
      m   = per ? $urandom_range(1, 3) : 1;
      do_start(k, p, per, en, e0);
      push_matches(e0, k, p, m);
      wait_until(e0 + m * (k * (p + 1) + 2));
      check("rnd_flags", {irq_status, irq, overrun}, {1'b1, en, (m >= 2)});
      check("rnd_count", match_count, m);
      if (!per) begin
        tick();
        check("rnd_oneshot", {done, tmr_enable, counter}, {1'b1, 1'b0, k});
      end
      do_stop();
      check("rnd_stop", busy, 0);
    end

    repeat (4) tick();
    check("pending_matches", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
